// File: rtl/alu_multiciclo.sv
// Registered execute-stage ALU: single-cycle add/sub/logic/compare ops and an
// iterative shift-add unsigned multiply, with a valid/ready input handshake.
module alu_multiciclo #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operando1,
    input  logic [WIDTH-1:0] operando2,
    output logic             out_valid,
    output logic [WIDTH-1:0] resultado,
    output logic [WIDTH-1:0] resultado_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_MULU = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;

    assign in_ready = (state == IDLE);
    assign busy     = (state == MUL);

    always_comb begin
        sum_add = {1'b0, operando1} + {1'b0, operando2};
        sum_sub = {1'b0, operando1} + {1'b0, ~operando2} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_add[WIDTH-1:0];
                alu_c   = sum_add[WIDTH];
                alu_v   = (operando1[WIDTH-1] == operando2[WIDTH-1]) &&
                          (sum_add[WIDTH-1] != operando1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sum_sub[WIDTH-1:0];
                alu_c   = sum_sub[WIDTH];
                alu_v   = (operando1[WIDTH-1] != operando2[WIDTH-1]) &&
                          (sum_sub[WIDTH-1] != operando1[WIDTH-1]);
            end
            OP_AND:  alu_res = operando1 & operando2;
            OP_OR:   alu_res = operando1 | operando2;
            OP_XOR:  alu_res = operando1 ^ operando2;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(operando1) < $signed(operando2))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (operando1 < operando2)};
            default: alu_res = '0;
        endcase

        // Product register is {p_hi, p_lo}; the multiplier shifts out of p_lo as the product shifts in.
        mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], p_lo[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            mcand        <= '0;
            p_hi         <= '0;
            p_lo         <= '0;
            out_valid    <= 1'b0;
            resultado    <= '0;
            resultado_hi <= '0;
            zero         <= 1'b0;
            carry        <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MULU) begin
                            mcand <= operando1;
                            p_lo  <= operando2;
                            p_hi  <= '0;
                            cnt   <= '0;
                            state <= MUL;
                        end else begin
                            resultado    <= alu_res;
                            resultado_hi <= '0;
                            zero         <= (alu_res == '0);
                            carry        <= alu_c;
                            overflow     <= alu_v;
                            out_valid    <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    p_hi <= mul_hi_n;
                    p_lo <= mul_lo_n;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        resultado    <= mul_lo_n;
                        resultado_hi <= mul_hi_n;
                        zero         <= (mul_lo_n == '0);
                        carry        <= 1'b0;
                        overflow     <= (mul_hi_n != '0);
                        out_valid    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
Parametrised, registered successor to the datapath's combinational 32-bit adder. It performs add, subtract, logic, set-less-than and an iterative unsigned multiply, and produces zero, carry and overflow flags. A valid/ready input handshake and a one-cycle output-valid pulse let the control unit issue single-cycle ops back-to-back and stall during multiply. The block sits in the execute stage, between the register-file read ports and the write-back mux.

Parameters:
WIDTH, 32, operand/result width in bits (≥4)
CNT_W, $clog2(WIDTH+1), multiply iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands/op valid this cycle
in_ready  output  1  block can accept an op this cycle
op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 SLTU, 111 MULU
operando1  input  WIDTH  operand A
operando2  input  WIDTH  operand B
out_valid  output  1  one-cycle pulse: result/flags updated
resultado  output  WIDTH  result (low half for MULU)
resultado_hi  output  WIDTH  high half of MULU product, else 0
zero  output  1  resultado == 0
carry  output  1  see flag rules
overflow  output  1  see flag rules
busy  output  1  multiply in progress (= ~in_ready)

Behaviour:
- Reset: the state goes to IDLE and the counter to 0. All outputs are 0 (resultado, resultado_hi, zero, carry, overflow, out_valid, busy), except in_ready = 1. Reset takes priority over everything, including mid-multiply: the multiply is aborted and no out_valid is generated.
- Accept: an op is accepted on an edge where in_valid & in_ready.
- States: IDLE, MUL.
- IDLE: in_ready = 1.
  - Accepted op ≠ MULU: compute combinationally and register into the outputs on the accept edge. out_valid = 1 for the following cycle (latency 1). Stay in IDLE, so back-to-back ops give back-to-back out_valid pulses.
  - Accepted MULU: latch the operands, clear the accumulator and counter, go to MUL. out_valid stays 0.
- MUL: in_ready = 0 and busy = 1. in_valid is ignored and operando1/operando2/op changes have no effect.
  - One shift-add iteration per edge, WIDTH iterations total.
  - On the edge completing iteration WIDTH: write {resultado_hi, resultado} = 2·WIDTH-bit product, set out_valid = 1, return to IDLE.
  - out_valid is therefore seen WIDTH+1 cycles after the accept edge; in_ready is high in the same cycle as that out_valid.
- Outputs hold their last value until the next out_valid update. out_valid is never high two cycles for the same op.
- Arithmetic (all modulo 2^WIDTH):
  - ADD: resultado = A+B. carry = carry-out bit WIDTH. overflow = signed overflow (A,B same sign, result sign differs).
  - SUB: resultado = A+~B+1. carry = carry-out of that sum (1 ⇔ A ≥ B unsigned). overflow = A,B differ in sign and result sign ≠ A sign.
  - AND/OR/XOR: bitwise. carry = overflow = 0.
  - SLT: resultado = {0…,1} if $signed(A) < $signed(B), else 0. carry = overflow = 0.
  - SLTU: as SLT but unsigned compare.
  - MULU: unsigned product. carry = 0. overflow = (resultado_hi ≠ 0).
  - resultado_hi = 0 for every op except MULU.
- zero reflects resultado only, never resultado_hi.
- Simultaneous in_valid with rst: rst wins and the op is dropped.

Test Plan:
- rst=1 for 2 cycles → all outputs 0, in_ready=1. Then ADD 00000001+00000002 → next cycle out_valid=1, resultado=00000003, zero=0, carry=0, overflow=0.
- ADD FFFFFFFF+00000001 → resultado=00000000, zero=1, carry=1, overflow=0. ADD 7FFFFFFF+00000001 → 80000000, overflow=1, carry=0.
- SUB 00000005−00000007 → FFFFFFFE, carry=0. SLT FFFFFFFF,00000001 → 00000001. SLTU same operands → 00000000, zero=1. Issue all three back-to-back → three consecutive out_valid pulses.
- MULU FFFFFFFF×FFFFFFFF → in_ready=0 for 32 cycles. out_valid exactly 33 cycles after accept, with resultado_hi=FFFFFFFE, resultado=00000001, overflow=1. MULU 00000003×00000004 → 0000000C, resultado_hi=0, overflow=0.
- During MULU, drive in_valid=1 with ADD and change the operands → ignored, product unchanged, no extra out_valid.
- Assert rst at cycle 10 of a MULU → next cycle IDLE, in_ready=1, outputs 0, no out_valid. A following ADD 2+2 → 00000004.
